target_round_ctrl: RTL and testbench
====================================

// Module: target_round_ctrl
//
// PURPOSE
//   Game-round controller that sits directly downstream of the difficulty tick generator.
//   - Consumes the tick strobe produced for the current difficulty.
//   - On each tick, lights one pseudo-random target LED and scores the player's button press.
//   - Drives difficulty back to the tick generator, closing the speed loop.
//
// PARAMETERS
//   NUM_TARGETS    4        number of LEDs/buttons; power of two, 2..16; IW = log2(NUM_TARGETS)
//   LFSR_SEED      16'hACE1 LFSR reset/reload value; must be non-zero
//   LEVEL_UP_HITS  4        consecutive hits needed to raise difficulty by one
//   MAX_MISSES     3        misses that end the game; 1..255
//
// PORTS
//   clk         in   1            clock
//   rst         in   1            reset: asynchronous, active-high
//   start       in   1            one-cycle start pulse; honoured only in IDLE or OVER
//   tick        in   1            strobe from the tick generator; each high cycle is one tick
//   btn         in   NUM_TARGETS  debounced, clk-synchronous button levels
//   target      out  NUM_TARGETS  one-hot lit LED; all zero when no target is lit
//   difficulty  out  3            level 0..4 fed to the tick generator
//   score       out  8            hit count, saturates at 255
//   misses      out  8            miss count
//   hit_pulse   out  1            one-cycle pulse per scored hit
//   miss_pulse  out  1            one-cycle pulse per miss
//   game_over   out  1            high while in OVER
//
// BEHAVIOUR
//   Reset values
//   - All outputs 0, state IDLE, LFSR = LFSR_SEED, btn_q = 0, streak = 0, last_idx = 0.
//   - All registers are async-cleared and clocked on posedge clk.
//
//   LFSR
//   - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11, advances every clk outside reset.
//   - If the LFSR ever reads 0 it reloads LFSR_SEED.
//   - Candidate index: idx = lfsr[IW-1:0]. If idx == last_idx, use (last_idx+1) mod NUM_TARGETS.
//   - Result: the same LED is never lit twice in a row.
//
//   Button edge
//   - btn_q <= btn every cycle; rise = btn & ~btn_q.
//   - "Correct" means rise & target != 0. "Wrong" means rise & ~target != 0 with no correct bit.
//   - Rises outside SHOW are ignored.
//
//   Outputs and latency
//   - All outputs are registered. An event sampled in cycle N is visible in cycle N+1.
//   - hit_pulse and miss_pulse are high for exactly one cycle and are never high together.
//
//   State machine
//   - IDLE:  start -> clear score, misses, difficulty and streak; go to ARMED.
//   - ARMED: tick -> target <= onehot(idx), last_idx <= idx; go to SHOW.
//   - SHOW, evaluated in priority order:
//     1. Correct -> score+1 (saturating), hit_pulse, target <= 0, streak+1. If streak+1 ==
//        LEVEL_UP_HITS: streak <= 0, and difficulty+1 if difficulty < 4. Go to ARMED.
//        A tick in the same cycle is consumed by the hit, not counted as a miss.
//     2. Wrong -> miss handling; target <= 0; go to ARMED.
//     3. Tick -> miss handling; immediately light a new target (same rules as ARMED); stay in SHOW.
//   - Miss handling: misses+1, miss_pulse, streak <= 0, difficulty unchanged.
//     If misses+1 == MAX_MISSES: target <= 0 and go to OVER. This overrides the next state of 2 and 3.
//   - OVER: game_over = 1, target = 0; score, misses and difficulty hold.
//     start -> clear as in IDLE; go to ARMED; game_over drops the next cycle.
//   - start in ARMED or SHOW is ignored.
//   - rst asserted mid-round returns to reset values immediately, with no pulse emitted.
//
// TESTING
//   1. Reset, then start, then tick.
//      -> target is one-hot one cycle later; difficulty = 0, score = 0.
//   2. Four correct hits, each after a tick.
//      -> score = 4, difficulty = 1, four hit_pulses. Repeat to level 4:
//      -> difficulty holds at 4 with 20+ hits.
//   3. Let three ticks expire with no press.
//      -> miss_pulse x3, misses = 3, game_over = 1, target = 0.
//      -> start then clears misses/score to 0, game_over = 0.
//   4. Correct rise and tick in the same cycle.
//      -> hit_pulse only, score+1, misses unchanged, state ARMED.
//   5. Wrong button while the target is lit (NUM_TARGETS = 4).
//      -> miss_pulse, streak reset: 3 hits + 1 wrong + 3 hits leaves difficulty = 0.
//   6. 1000 consecutive target lightings.
//      -> no consecutive repeat of the lit index; every index is used; target is always
//         one-hot or zero; rst mid-SHOW clears all outputs asynchronously.

Source files
------------

// File: rtl/target_round_ctrl.sv
// target_round_ctrl
//   Game-round controller fed by the difficulty tick generator. Each tick lights
//   one pseudo-random target LED. The player's button rises are scored as hits or
//   misses, and the difficulty level is driven back to the tick generator.
//
// Ports
//   clk         clock
//   rst         asynchronous, active-high reset
//   start       one-cycle start pulse, honoured in IDLE or OVER only
//   tick        tick strobe; each high cycle is one tick
//   btn         debounced, clk-synchronous button levels
//   target      one-hot lit LED, zero when nothing is lit
//   difficulty  level 0..4 for the tick generator
//   score       hit count, saturating at 255
//   misses      miss count
//   hit_pulse   one-cycle pulse per scored hit
//   miss_pulse  one-cycle pulse per miss
//   game_over   high while in OVER
//
// State  | meaning
// -------+-----------------------------------------------------
// IDLE   | after reset, waiting for start
// ARMED  | round running, no target lit, waiting for a tick
// SHOW   | target lit, waiting for a press or the next tick
// OVER   | miss limit reached; results held until start

module target_round_ctrl #(
    parameter int          NUM_TARGETS   = 4,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          LEVEL_UP_HITS = 4,
    parameter int          MAX_MISSES    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   tick,
    input  logic [NUM_TARGETS-1:0] btn,
    output logic [NUM_TARGETS-1:0] target,
    output logic [2:0]             difficulty,
    output logic [7:0]             score,
    output logic [7:0]             misses,
    output logic                   hit_pulse,
    output logic                   miss_pulse,
    output logic                   game_over
);

    localparam int IW = $clog2(NUM_TARGETS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_SHOW  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t                 state, state_nx;
    logic [15:0]            lfsr, lfsr_nx;
    logic [NUM_TARGETS-1:0] btn_q, rise;
    logic                   correct, wrong;
    logic [7:0]             streak, streak_nx;
    logic [IW-1:0]          last_idx, last_idx_nx, cand_idx, pick_idx;
    logic [NUM_TARGETS-1:0] lit_onehot;
    logic [NUM_TARGETS-1:0] target_nx;
    logic [2:0]             difficulty_nx;
    logic [7:0]             score_nx, misses_nx;
    logic                   hit_nx, miss_nx, game_over_nx;
    logic                   last_miss;

    // Galois right-shift form of x^16+x^14+x^13+x^11; a zero state is
    // unrecoverable, so it reloads the seed instead.
    assign lfsr_nx = (lfsr == 16'h0000) ? LFSR_SEED
                   : ({1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000));

    // Bumping a repeated candidate by one guarantees a different LED each lighting;
    // the IW-bit add wraps because NUM_TARGETS is a power of two.
    assign cand_idx = lfsr[IW-1:0];
    assign pick_idx = (cand_idx == last_idx) ? (last_idx + IW'(1)) : cand_idx;

    always_comb begin
        lit_onehot           = '0;
        lit_onehot[pick_idx] = 1'b1;
    end

    assign rise      = btn & ~btn_q;
    assign correct   = |(rise & target);
    assign wrong     = ~correct & |(rise & ~target);
    assign last_miss = ((misses + 8'd1) == 8'(MAX_MISSES));

    always_comb begin
        state_nx      = state;
        target_nx     = target;
        difficulty_nx = difficulty;
        score_nx      = score;
        misses_nx     = misses;
        streak_nx     = streak;
        last_idx_nx   = last_idx;
        hit_nx        = 1'b0;
        miss_nx       = 1'b0;

        case (state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    score_nx      = 8'd0;
                    misses_nx     = 8'd0;
                    difficulty_nx = 3'd0;
                    streak_nx     = 8'd0;
                    state_nx      = S_ARMED;
                end
            end
            S_ARMED: begin
                if (tick) begin
                    target_nx   = lit_onehot;
                    last_idx_nx = pick_idx;
                    state_nx    = S_SHOW;
                end
            end
            S_SHOW: begin
                if (correct) begin
                    // A tick in the same cycle is absorbed by the hit.
                    score_nx  = (score == 8'hFF) ? score : score + 8'd1;
                    hit_nx    = 1'b1;
                    target_nx = '0;
                    streak_nx = streak + 8'd1;
                    if ((streak + 8'd1) == 8'(LEVEL_UP_HITS)) begin
                        streak_nx = 8'd0;
                        if (difficulty < 3'd4) begin
                            difficulty_nx = difficulty + 3'd1;
                        end
                    end
                    state_nx = S_ARMED;
                end else if (wrong || tick) begin
                    misses_nx = misses + 8'd1;
                    miss_nx   = 1'b1;
                    streak_nx = 8'd0;
                    if (last_miss) begin
                        // last_idx keeps the previously lit LED so the no-repeat
                        // rule still holds across a restart.
                        target_nx = '0;
                        state_nx  = S_OVER;
                    end else if (wrong) begin
                        target_nx = '0;
                        state_nx  = S_ARMED;
                    end else begin
                        target_nx   = lit_onehot;
                        last_idx_nx = pick_idx;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase

        game_over_nx = (state_nx == S_OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr       <= LFSR_SEED;
            btn_q      <= '0;
            streak     <= 8'd0;
            last_idx   <= '0;
            target     <= '0;
            difficulty <= 3'd0;
            score      <= 8'd0;
            misses     <= 8'd0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            lfsr       <= lfsr_nx;
            btn_q      <= btn;
            streak     <= streak_nx;
            last_idx   <= last_idx_nx;
            target     <= target_nx;
            difficulty <= difficulty_nx;
            score      <= score_nx;
            misses     <= misses_nx;
            hit_pulse  <= hit_nx;
            miss_pulse <= miss_nx;
            game_over  <= game_over_nx;
        end
    end

endmodule

// File: tb/tb_target_round_ctrl.sv
module tb_target_round_ctrl;

    localparam int          NT       = 4;
    localparam logic [15:0] SEED     = 16'hACE1;
    localparam int          LVL_HITS = 4;
    localparam int          MAXM     = 3;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_SHOW  = 2;
    localparam int M_OVER  = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic          tick;
    logic [NT-1:0] btn;
    logic [NT-1:0] target;
    logic [2:0]    difficulty;
    logic [7:0]    score;
    logic [7:0]    misses;
    logic          hit_pulse;
    logic          miss_pulse;
    logic          game_over;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model (game rules, plain integers)
    int            m_mode;
    int            m_lfsr;
    logic [NT-1:0] m_btn_q;
    int            m_streak;
    int            m_last;
    logic [NT-1:0] m_target;
    int            m_diff;
    int            m_score;
    int            m_misses;
    bit            m_hit;
    bit            m_miss;
    bit            m_lit;

    target_round_ctrl #(
        .NUM_TARGETS(NT),
        .LFSR_SEED(SEED),
        .LEVEL_UP_HITS(LVL_HITS),
        .MAX_MISSES(MAXM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .tick(tick),
        .btn(btn),
        .target(target),
        .difficulty(difficulty),
        .score(score),
        .misses(misses),
        .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse),
        .game_over(game_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_lfsr   = int'(SEED);
        m_btn_q  = '0;
        m_streak = 0;
        m_last   = 0;
        m_target = '0;
        m_diff   = 0;
        m_score  = 0;
        m_misses = 0;
        m_hit    = 0;
        m_miss   = 0;
        m_lit    = 0;
    endtask

    task automatic model_light(input int lf);
        int idx;
        idx = lf % NT;
        if (idx == m_last) idx = (m_last + 1) % NT;
        m_target      = '0;
        m_target[idx] = 1'b1;
        m_last        = idx;
        m_lit         = 1;
    endtask

    task automatic model_step(input logic st, input logic tk, input logic [NT-1:0] b);
        logic [NT-1:0] rise;
        int            lf_old;
        rise    = b & ~m_btn_q;
        m_btn_q = b;
        lf_old  = m_lfsr;
        if (m_lfsr == 0) m_lfsr = int'(SEED);
        else m_lfsr = (m_lfsr / 2) ^ ((m_lfsr % 2) * 'hB400);
        m_hit  = 0;
        m_miss = 0;
        m_lit  = 0;
        case (m_mode)
            M_IDLE, M_OVER: begin
                if (st) begin
                    m_score  = 0;
                    m_misses = 0;
                    m_diff   = 0;
                    m_streak = 0;
                    m_mode   = M_ARMED;
                end
            end
            M_ARMED: begin
                if (tk) begin
                    model_light(lf_old);
                    m_mode = M_SHOW;
                end
            end
            default: begin
                if ((rise & m_target) != 0) begin
                    if (m_score < 255) m_score = m_score + 1;
                    m_hit    = 1;
                    m_target = '0;
                    m_streak = m_streak + 1;
                    if (m_streak == LVL_HITS) begin
                        m_streak = 0;
                        if (m_diff < 4) m_diff = m_diff + 1;
                    end
                    m_mode = M_ARMED;
                end else if (rise != 0 || tk) begin
                    m_misses = m_misses + 1;
                    m_miss   = 1;
                    m_streak = 0;
                    if (m_misses == MAXM) begin
                        m_target = '0;
                        m_mode   = M_OVER;
                    end else if (rise != 0) begin
                        m_target = '0;
                        m_mode   = M_ARMED;
                    end else begin
                        model_light(lf_old);
                    end
                end
            end
        endcase
    endtask

    function automatic logic [NT+21:0] exp_vec();
        return {m_target, 3'(m_diff), 8'(m_score), 8'(m_misses),
                m_hit, m_miss, (m_mode == M_OVER)};
    endfunction

    // One clock: inputs are applied away from the edge, model advances at the edge,
    // and the caller samples outputs 1 time unit later.
    task automatic drive(input logic st, input logic tk, input logic [NT-1:0] b);
        start = st;
        tick  = tk;
        btn   = b;
        @(posedge clk);
        model_step(st, tk, b);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick  = 1'b0;
        btn   = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (target !== '0) begin n_fail++; $display("FAIL reset_target got %b want 0", target); end
        n_tests++;
        if (difficulty !== 3'd0 || score !== 8'd0 || misses !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_counts got d=%0d s=%0d m=%0d want all 0", difficulty, score, misses);
        end
        n_tests++;
        if ({hit_pulse, miss_pulse, game_over} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 000", {hit_pulse, miss_pulse, game_over});
        end
    endtask

    task automatic test_start_tick();
        drive(1'b1, 1'b0, '0);
        n_tests++;
        if (target !== '0) begin n_fail++; $display("FAIL start_no_target got %b want 0", target); end
        drive(1'b0, 1'b1, '0);
        n_tests++;
        if (!$onehot(target) || target !== m_target) begin
            n_fail++;
            $display("FAIL first_target got %b want %b", target, m_target);
        end
        n_tests++;
        if (difficulty !== 3'd0 || score !== 8'd0) begin
            n_fail++;
            $display("FAIL first_counts got d=%0d s=%0d want 0 0", difficulty, score);
        end
    endtask

    task automatic test_level_up();
        int hits_seen;
        int want_d;
        hits_seen = 0;
        for (int h = 1; h <= 24; h++) begin
            drive(1'b0, 1'b0, m_target);
            if (hit_pulse === 1'b1) hits_seen++;
            want_d = (h / LVL_HITS > 4) ? 4 : h / LVL_HITS;
            n_tests++;
            if (score !== 8'(h) || difficulty !== 3'(want_d) || miss_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL level_hit%0d got s=%0d d=%0d mp=%b want s=%0d d=%0d mp=0",
                         h, score, difficulty, miss_pulse, h, want_d);
            end
            drive(1'b0, 1'b1, '0);
            n_tests++;
            if (hit_pulse !== 1'b0 || target !== m_target || target === '0) begin
                n_fail++;
                $display("FAIL level_relight%0d got hp=%b t=%b want hp=0 t=%b", h, hit_pulse, target, m_target);
            end
        end
        n_tests++;
        if (hits_seen != 24) begin n_fail++; $display("FAIL level_pulses got %0d want 24", hits_seen); end
    endtask

    task automatic test_miss_out();
        for (int i = 1; i <= MAXM; i++) begin
            drive(1'b0, 1'b1, '0);
            n_tests++;
            if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0 || misses !== 8'(i)) begin
                n_fail++;
                $display("FAIL miss_tick%0d got mp=%b hp=%b m=%0d want mp=1 hp=0 m=%0d",
                         i, miss_pulse, hit_pulse, misses, i);
            end
        end
        n_tests++;
        if (game_over !== 1'b1 || target !== '0 || score !== 8'd24 || difficulty !== 3'd4) begin
            n_fail++;
            $display("FAIL over_state got go=%b t=%b s=%0d d=%0d want go=1 t=0 s=24 d=4",
                     game_over, target, score, difficulty);
        end
        drive(1'b0, 1'b1, 4'b0001);
        n_tests++;
        if (game_over !== 1'b1 || misses !== 8'd3 || miss_pulse !== 1'b0 || target !== '0) begin
            n_fail++;
            $display("FAIL over_hold got go=%b m=%0d mp=%b t=%b want go=1 m=3 mp=0 t=0",
                     game_over, misses, miss_pulse, target);
        end
        drive(1'b1, 1'b0, '0);
        n_tests++;
        if (game_over !== 1'b0 || misses !== 8'd0 || score !== 8'd0 || difficulty !== 3'd0) begin
            n_fail++;
            $display("FAIL restart got go=%b m=%0d s=%0d d=%0d want 0 0 0 0",
                     game_over, misses, score, difficulty);
        end
    endtask

    task automatic test_hit_tick();
        drive(1'b0, 1'b1, '0);
        n_tests++;
        if (target === '0 || target !== m_target) begin
            n_fail++;
            $display("FAIL ht_light got %b want %b", target, m_target);
        end
        drive(1'b0, 1'b1, m_target);
        n_tests++;
        if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || score !== 8'd1 || misses !== 8'd0 || target !== '0) begin
            n_fail++;
            $display("FAIL hit_and_tick got hp=%b mp=%b s=%0d m=%0d t=%b want hp=1 mp=0 s=1 m=0 t=0",
                     hit_pulse, miss_pulse, score, misses, target);
        end
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b1, '0);
        n_tests++;
        if (miss_pulse !== 1'b0 || misses !== 8'd0 || target === '0 || target !== m_target) begin
            n_fail++;
            $display("FAIL ht_armed got mp=%b m=%0d t=%b want mp=0 m=0 t=%b",
                     miss_pulse, misses, target, m_target);
        end
    endtask

    task automatic test_wrong_streak();
        logic [NT-1:0] wb;
        drive(1'b0, 1'b1, '0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, m_target);
            drive(1'b0, 1'b1, '0);
        end
        wb = {m_target[NT-2:0], m_target[NT-1]};
        drive(1'b0, 1'b0, wb);
        n_tests++;
        if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0 || target !== '0 || misses !== 8'd2) begin
            n_fail++;
            $display("FAIL wrong_btn got mp=%b hp=%b t=%b m=%0d want mp=1 hp=0 t=0 m=2",
                     miss_pulse, hit_pulse, target, misses);
        end
        drive(1'b0, 1'b1, '0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, m_target);
            drive(1'b0, 1'b1, '0);
        end
        n_tests++;
        if (difficulty !== 3'd0 || score !== 8'd7 || misses !== 8'd2 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL streak_reset got d=%0d s=%0d m=%0d go=%b want d=0 s=7 m=2 go=0",
                     difficulty, score, misses, game_over);
        end
    endtask

    task automatic test_random();
        int            lit_count;
        int            cyc;
        int            prev_idx;
        bit            have_prev;
        bit [NT-1:0]   used;
        int            dut_idx;
        int            sel;
        logic          st, tk;
        logic [NT-1:0] b;
        logic [NT+21:0] want;
        lit_count = 0;
        cyc       = 0;
        have_prev = 0;
        prev_idx  = 0;
        used      = '0;
        while (lit_count < 1000 && cyc < 40000) begin
            st  = ($urandom_range(0, 7) == 0);
            tk  = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 3);
            if (sel < 2) b = '0;
            else if (sel == 2) b = m_target;
            else b = NT'($urandom);
            drive(st, tk, b);
            cyc++;
            want = exp_vec();
            n_tests++;
            if ({target, difficulty, score, misses, hit_pulse, miss_pulse, game_over} !== want) begin
                n_fail++;
                $display("FAIL rand_cycle%0d got %h want %h", cyc,
                         {target, difficulty, score, misses, hit_pulse, miss_pulse, game_over}, want);
            end
            n_tests++;
            if (!$onehot0(target) || (hit_pulse && miss_pulse)) begin
                n_fail++;
                $display("FAIL rand_shape%0d got t=%b hp=%b mp=%b want onehot0 and not both pulses",
                         cyc, target, hit_pulse, miss_pulse);
            end
            if (m_lit) begin
                lit_count++;
                dut_idx = -1;
                for (int i = 0; i < NT; i++) if (target[i] === 1'b1) dut_idx = i;
                if (dut_idx >= 0) begin
                    n_tests++;
                    if (have_prev && dut_idx == prev_idx) begin
                        n_fail++;
                        $display("FAIL rand_repeat got idx %0d twice want different", dut_idx);
                    end
                    used[dut_idx] = 1'b1;
                    prev_idx      = dut_idx;
                    have_prev     = 1;
                end
            end
        end
        n_tests++;
        if (lit_count < 1000) begin
            n_fail++;
            $display("FAIL rand_budget got %0d lightings want 1000", lit_count);
        end
        n_tests++;
        if (used !== {NT{1'b1}}) begin
            n_fail++;
            $display("FAIL rand_coverage got %b want all ones", used);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 1'b0, '0);
        drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, m_target);
        drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, m_target);
        n_tests++;
        if (hit_pulse !== 1'b1 || score !== 8'd2) begin
            n_fail++;
            $display("FAIL pre_reset got hp=%b s=%0d want hp=1 s=2", hit_pulse, score);
        end
        drive(1'b0, 1'b1, '0);
        #3;
        rst = 1'b1;
        #2;
        n_tests++;
        if ({target, difficulty, score, misses, hit_pulse, miss_pulse, game_over} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got t=%b d=%0d s=%0d m=%0d flags=%b want all 0",
                     target, difficulty, score, misses, {hit_pulse, miss_pulse, game_over});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(1'b0, 1'b1, '0);
        n_tests++;
        if (target !== '0 || miss_pulse !== 1'b0 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle got t=%b mp=%b go=%b want 0 0 0", target, miss_pulse, game_over);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        tick  = 1'b0;
        btn   = '0;
        model_reset();
        test_reset();
        test_start_tick();
        test_level_up();
        test_miss_out();
        test_hit_tick();
        test_wrong_streak();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
